// File: rtl/echo_delay_line.sv
// Feedback echo stage: samples the synthesizer stream at the audio rate and adds an attenuated copy
// from a ring buffer. After reset the buffer is cleared before any sample is accepted.
`timescale 1ns / 1ps

module echo_delay_line #(
  parameter int unsigned clk_mhz        = 50,
  parameter int unsigned sample_rate_hz = 12000,
  parameter int unsigned w_addr         = 12,
  parameter int unsigned w_sample       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [w_sample-1:0] sound_in,
  input  logic                       enable,
  input  logic        [w_addr-1:0]   delay,
  input  logic        [1:0]          decay,
  output logic signed [w_sample-1:0] sound,
  output logic                       sample_valid,
  output logic                       busy
);

  localparam int unsigned Period = (clk_mhz * 1000000) / sample_rate_hz;
  localparam int unsigned WCnt   = (Period > 1) ? $clog2(Period) : 1;
  localparam int unsigned Depth  = 2 ** w_addr;

  // MIX occupies the cycle after a tick, so consecutive ticks must be well apart.
  if (Period < 3) begin : g_period_check
    $error("echo_delay_line: sample period must be at least 3 clock cycles");
  end

  typedef enum logic [1:0] {StClear, StIdle, StMix} state_e;

  state_e                     state_q, state_d;
  logic [WCnt-1:0]            tick_cnt_q, tick_cnt_d;
  logic [w_addr-1:0]          clear_cnt_q, clear_cnt_d;
  logic [w_addr-1:0]          wr_ptr_q, wr_ptr_d;
  logic signed [w_sample-1:0] s_in_q, s_in_d;
  logic [w_addr-1:0]          d_q, d_d;
  logic [2:0]                 sh_q, sh_d;
  logic                       en_q, en_d;
  logic signed [w_sample-1:0] sound_q, sound_d;
  logic                       valid_q, valid_d;
  logic                       tick;

  logic                       ram_we, ram_re;
  logic [w_addr-1:0]          ram_waddr, ram_raddr;
  logic [w_sample-1:0]        ram_wdata;
  logic [w_sample-1:0]        ram_rdata;
  logic [w_sample-1:0]        mem [Depth];

  logic signed [w_sample-1:0] echo;
  logic signed [w_sample:0]   sum;
  logic signed [w_sample-1:0] sat_sum;
  logic signed [w_sample-1:0] mixed;

  // Tick generator, parked at zero while the buffer is being cleared.
  always_comb begin
    tick       = (state_q != StClear) && (tick_cnt_q == WCnt'(Period - 1));
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (state_q == StClear || tick) begin
      tick_cnt_d = '0;
    end
  end

  always_comb begin
    echo = '0;
    if (en_q && (d_q != '0)) begin
      echo = $signed(ram_rdata) >>> sh_q;
    end
    sum     = {s_in_q[w_sample-1], s_in_q} + {echo[w_sample-1], echo};
    sat_sum = sum[w_sample-1:0];
    // Sign bits disagree on overflow; clamp toward the sign of the true result.
    if (sum[w_sample] != sum[w_sample-1]) begin
      sat_sum = sum[w_sample] ? {1'b1, {(w_sample - 1){1'b0}}} : {1'b0, {(w_sample - 1){1'b1}}};
    end
    mixed = en_q ? sat_sum : s_in_q;
  end

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    s_in_d      = s_in_q;
    d_d         = d_q;
    sh_d        = sh_q;
    en_d        = en_q;
    sound_d     = sound_q;
    valid_d     = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = wr_ptr_q;
    ram_wdata   = mixed;
    ram_re      = 1'b0;
    ram_raddr   = wr_ptr_q - delay;

    unique case (state_q)
      StClear: begin
        ram_we      = 1'b1;
        ram_waddr   = clear_cnt_q;
        ram_wdata   = '0;
        clear_cnt_d = clear_cnt_q + 1'b1;
        if (&clear_cnt_q) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (tick) begin
          s_in_d  = sound_in;
          d_d     = delay;
          sh_d    = {1'b0, decay} + 3'd1;
          en_d    = enable;
          ram_re  = 1'b1;
          state_d = StMix;
        end
      end
      StMix: begin
        sound_d  = mixed;
        valid_d  = 1'b1;
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StClear;
      tick_cnt_q  <= '0;
      clear_cnt_q <= '0;
      wr_ptr_q    <= '0;
      s_in_q      <= '0;
      d_q         <= '0;
      sh_q        <= 3'd1;
      en_q        <= 1'b0;
      sound_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      clear_cnt_q <= clear_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      s_in_q      <= s_in_d;
      d_q         <= d_d;
      sh_q        <= sh_d;
      en_q        <= en_d;
      sound_q     <= sound_d;
      valid_q     <= valid_d;
    end
  end

  // Ring buffer: synchronous write and registered read; CLEAR never overlaps a read.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    if (ram_re) begin
      ram_rdata <= mem[ram_raddr];
    end
  end

  assign sound        = sound_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q == StClear);

endmodule

// File: tb/tb_echo_delay_line.sv
// Directed bench for echo_delay_line, run with a short sample period and a 256-entry buffer
// so that echo, saturation and pointer-wrap cases fit in a short simulation.
`timescale 1ns / 1ps

module tb_echo_delay_line;

  localparam int unsigned ClkMhz  = 1;
  localparam int unsigned Rate    = 125000;
  localparam int unsigned WAddr   = 8;
  localparam int unsigned WSample = 16;
  localparam int          P       = 8;
  localparam int          Depth   = 256;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic signed [WSample-1:0] sound_in = '0;
  logic                      enable = 1'b0;
  logic        [WAddr-1:0]   delay = '0;
  logic        [1:0]         decay = '0;
  logic signed [WSample-1:0] sound;
  logic                      sample_valid;
  logic                      busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int rel_cyc  = 0;

  echo_delay_line #(
    .clk_mhz       (ClkMhz),
    .sample_rate_hz(Rate),
    .w_addr        (WAddr),
    .w_sample      (WSample)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sound_in    (sound_in),
    .enable      (enable),
    .delay       (delay),
    .decay       (decay),
    .sound       (sound),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  // Hold reset, preset the inputs for sample 0, release and wait for the clear to end.
  task automatic do_reset(input int en, input int dly, input int dcy, input int first,
                          output int busy_cycles);
    int saw_valid;
    rst      = 1'b1;
    enable   = en[0];
    delay    = WAddr'(dly);
    decay    = 2'(dcy);
    sound_in = WSample'(first);
    repeat (2) @(negedge clk);
    rst         = 1'b0;
    rel_cyc     = cyc;
    saw_valid   = 0;
    busy_cycles = -1;
    for (int i = 0; i < Depth + 10; i++) begin
      @(negedge clk);
      if (sample_valid) saw_valid = 1;
      if (!busy) begin
        busy_cycles = cyc - rel_cyc;
        break;
      end
    end
    check_eq("no_valid_during_clear", saw_valid, 0);
  endtask

  // Wait for the next output sample, then present the input for the following one.
  task automatic next_sample(input int next_in, output int got, output int at_cyc);
    got    = 0;
    at_cyc = -1;
    for (int i = 0; i < Depth + 4 * P; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        got    = sound;
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sample_timeout: no sample_valid within %0d cycles", Depth + 4 * P);
      finish_run();
    end
    sound_in = WSample'(next_in);
  endtask

  initial begin
    int y, c, prev, bc, exp;

    // Impulse with feedback: each echo is half of the previous one.
    do_reset(1, 100, 0, 1000, bc);
    for (int n = 0; n <= 310; n++) begin
      next_sample(0, y, c);
      exp = (n % 100 == 0) ? (1000 >> (n / 100)) : 0;
      check_eq($sformatf("impulse[%0d]", n), y, exp);
    end

    // Negative impulse, shift of 4, arithmetic rounding toward -inf.
    do_reset(1, 10, 3, -4096, bc);
    for (int n = 0; n <= 30; n++) begin
      next_sample(0, y, c);
      exp = (n == 0) ? -4096 : (n == 10) ? -256 : (n == 20) ? -16 : (n == 30) ? -1 : 0;
      check_eq($sformatf("neg_impulse[%0d]", n), y, exp);
    end

    do_reset(1, 1, 0, 30000, bc);
    for (int n = 0; n < 6; n++) begin
      next_sample(30000, y, c);
      check_eq($sformatf("sat_pos[%0d]", n), y, (n == 0) ? 30000 : 32767);
    end

    // Asynchronous reset mid-run clears the output without waiting for a clock edge.
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_sound", sound, 0);
    check_eq("async_rst_busy", busy, 1);
    check_eq("async_rst_valid", sample_valid, 0);

    do_reset(1, 1, 0, -30000, bc);
    for (int n = 0; n < 6; n++) begin
      next_sample(-30000, y, c);
      check_eq($sformatf("sat_neg[%0d]", n), y, (n == 0) ? -30000 : -32768);
    end

    // Bypass: output follows input; check clear length, first latency and sample spacing.
    do_reset(0, 5, 0, 0, bc);
    check_eq("busy_cycles", bc, Depth);
    prev = 0;
    for (int n = 0; n < 20; n++) begin
      next_sample(n + 1, y, c);
      check_eq($sformatf("bypass[%0d]", n), y, n);
      if (n == 0) check_eq("first_valid_cycle", c - rel_cyc, Depth + P + 1);
      else        check_eq($sformatf("valid_spacing[%0d]", n), c - prev, P);
      prev = c;
      @(negedge clk);
      check_eq($sformatf("valid_pulse[%0d]", n), sample_valid, 0);
    end

    // Enabled with zero delay also passes straight through.
    do_reset(1, 0, 2, -5000, bc);
    for (int n = 0; n < 20; n++) begin
      next_sample((n + 1) * 1000 - 5000, y, c);
      check_eq($sformatf("zero_delay[%0d]", n), y, n * 1000 - 5000);
    end

    // Maximum delay: the echo of sample 200 lands at 455, after the write pointer wraps.
    do_reset(1, 255, 0, 0, bc);
    for (int n = 0; n <= 460; n++) begin
      next_sample((n + 1 == 200) ? 1000 : 0, y, c);
      exp = (n == 200) ? 1000 : (n == 455) ? 500 : 0;
      check_eq($sformatf("wrap[%0d]", n), y, exp);
    end

    finish_run();
  end

endmodule
